// File: rtl/lcd_host.sv
// -----------------------------------------------------------------------------
// lcd_host
//
// Command initiator for the 6x6-image / 3x3-window LCD controller.
// Holds one request at a time and hands it to the controller in the
// controller's command-accept cycle (lcd_busy low). For a load it streams the
// 36 image bytes. It gathers the nine returned window bytes into one packed
// result with a checksum. The controller samples lcd_cmd in every cycle where
// lcd_busy is low, so each idle slot carries an untracked refresh.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   req_valid/req_op   request strobe and opcode (0 refresh, 1 load,
//                      2 right, 3 left, 4 up, 5 down, 6-7 -> refresh)
//   req_ready          holding register empty
//   img_addr/img_rd    image byte address and read strobe while loading
//   img_data           image byte, combinational read of img_addr
//   res_valid          one-cycle pulse carrying a tracked result
//   res_op             op of the completed request
//   res_window         window bytes, byte i in [8i+7:8i], raster order
//   res_sum            sum of the nine window bytes
//   host_busy          a request is held or a tracked command is in flight
//   lcd_cmd/_valid     command and strobe to the controller
//   lcd_datain         load byte to the controller
//   lcd_dataout        window byte from the controller
//   lcd_output_valid   window byte strobe
//   lcd_busy           controller busy; low marks the command-accept cycle
// -----------------------------------------------------------------------------
module lcd_host (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  output logic        req_ready,
  output logic [5:0]  img_addr,
  output logic        img_rd,
  input  logic [7:0]  img_data,
  output logic        res_valid,
  output logic [2:0]  res_op,
  output logic [71:0] res_window,
  output logic [11:0] res_sum,
  output logic        host_busy,
  output logic [2:0]  lcd_cmd,
  output logic        lcd_cmd_valid,
  output logic [7:0]  lcd_datain,
  input  logic [7:0]  lcd_dataout,
  input  logic        lcd_output_valid,
  input  logic        lcd_busy
);

  localparam logic [2:0] OP_REFRESH = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_MAX     = 3'd5;
  localparam logic [5:0] LAST_ADDR  = 6'd35;
  localparam logic [3:0] LAST_BYTE  = 4'd8;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  k_q, k_d;

  logic        hold_valid_q, hold_valid_d;
  logic [2:0]  hold_op_q, hold_op_d;
  logic        inflight_tracked_q, inflight_tracked_d;
  logic [2:0]  inflight_op_q, inflight_op_d;

  logic [71:0] win_q, win_d;
  logic [11:0] sum_q, sum_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        res_valid_q, res_valid_d;
  logic [2:0]  res_op_q, res_op_d;
  logic [71:0] res_window_q, res_window_d;
  logic [11:0] res_sum_q, res_sum_d;

  logic        issue;
  logic [2:0]  cmd_sel;
  logic [2:0]  req_op_norm;
  logic [71:0] win_shift;
  logic [11:0] sum_add;

  // The controller takes a command in every cycle where it is not busy.
  assign issue       = !lcd_busy;
  assign cmd_sel     = hold_valid_q ? hold_op_q : OP_REFRESH;
  // Undefined opcodes are folded to refresh at the door so the held op is
  // always something the controller understands.
  assign req_op_norm = (req_op > OP_MAX) ? OP_REFRESH : req_op;

  // Bytes arrive in raster order; shifting in at the top leaves byte 0 in the
  // low lane once all nine are in.
  assign win_shift   = {lcd_dataout, win_q[71:8]};
  assign sum_add     = sum_q + {4'd0, lcd_dataout};

  always_comb begin
    hold_valid_d       = hold_valid_q;
    hold_op_d          = hold_op_q;
    inflight_tracked_d = inflight_tracked_q;
    inflight_op_d      = inflight_op_q;
    state_d            = state_q;
    k_d                = k_q;
    win_d              = win_q;
    sum_d              = sum_q;
    cnt_d              = cnt_q;
    res_valid_d        = 1'b0;
    res_op_d           = res_op_q;
    res_window_d       = res_window_q;
    res_sum_d          = res_sum_q;

    // Hold register: drained by an issue, refilled only when empty. An empty
    // hold may still accept in an issue cycle; that slot goes out as refresh.
    if (hold_valid_q) begin
      if (issue) begin
        hold_valid_d = 1'b0;
      end
    end else if (req_valid) begin
      hold_valid_d = 1'b1;
      hold_op_d    = req_op_norm;
    end

    if (issue) begin
      inflight_tracked_d = hold_valid_q;
      inflight_op_d      = cmd_sel;
    end

    // Streaming side.
    case (state_q)
      ST_IDLE: begin
        if (issue && (cmd_sel == OP_LOAD)) begin
          state_d = ST_LOAD;
          k_d     = 6'd0;
        end
      end
      ST_LOAD: begin
        if (k_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          k_d     = 6'd0;
        end else begin
          k_d = k_q + 6'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = 6'd0;
      end
    endcase

    // Window capture. The ninth byte lands in the same cycle the next command
    // is issued, so completion looks at the pre-edge inflight_* values.
    if (lcd_output_valid) begin
      if (cnt_q == LAST_BYTE) begin
        cnt_d       = 4'd0;
        sum_d       = 12'd0;
        win_d       = 72'd0;
        res_valid_d = inflight_tracked_q;
        if (inflight_tracked_q) begin
          res_window_d = win_shift;
          res_sum_d    = sum_add;
          res_op_d     = inflight_op_q;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
        sum_d = sum_add;
        win_d = win_shift;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      k_q                <= 6'd0;
      hold_valid_q       <= 1'b0;
      hold_op_q          <= OP_REFRESH;
      inflight_tracked_q <= 1'b0;
      inflight_op_q      <= OP_REFRESH;
      win_q              <= 72'd0;
      sum_q              <= 12'd0;
      cnt_q              <= 4'd0;
      res_valid_q        <= 1'b0;
      res_op_q           <= 3'd0;
      res_window_q       <= 72'd0;
      res_sum_q          <= 12'd0;
    end else begin
      state_q            <= state_d;
      k_q                <= k_d;
      hold_valid_q       <= hold_valid_d;
      hold_op_q          <= hold_op_d;
      inflight_tracked_q <= inflight_tracked_d;
      inflight_op_q      <= inflight_op_d;
      win_q              <= win_d;
      sum_q              <= sum_d;
      cnt_q              <= cnt_d;
      res_valid_q        <= res_valid_d;
      res_op_q           <= res_op_d;
      res_window_q       <= res_window_d;
      res_sum_q          <= res_sum_d;
    end
  end

  assign req_ready     = !hold_valid_q;
  assign host_busy     = hold_valid_q | inflight_tracked_q;
  assign lcd_cmd_valid = issue;
  assign lcd_cmd       = cmd_sel;
  assign img_rd        = (state_q == ST_LOAD);
  assign img_addr      = img_rd ? k_q : 6'd0;
  assign lcd_datain    = img_rd ? img_data : 8'd0;
  assign res_valid     = res_valid_q;
  assign res_op        = res_op_q;
  assign res_window    = res_window_q;
  assign res_sum       = res_sum_q;

endmodule

// File: tb/tb_lcd_host.sv
// -----------------------------------------------------------------------------
// tb_lcd_host
//
// Directed bench for lcd_host. A small behavioural LCD controller answers the
// host: it takes a command when not busy, captures 36 load bytes after a
// load, keeps a clamped 3x3 window origin and returns nine window bytes on the
// documented schedule. The image source returns its own address as data.
// -----------------------------------------------------------------------------
module tb_lcd_host;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic        req_ready;
  logic [5:0]  img_addr;
  logic        img_rd;
  logic [7:0]  img_data;
  logic        res_valid;
  logic [2:0]  res_op;
  logic [71:0] res_window;
  logic [11:0] res_sum;
  logic        host_busy;
  logic [2:0]  lcd_cmd;
  logic        lcd_cmd_valid;
  logic [7:0]  lcd_datain;
  logic [7:0]  lcd_dataout = 8'd0;
  logic        lcd_output_valid = 1'b0;
  logic        lcd_busy = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign img_data = {2'b00, img_addr};

  lcd_host dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .req_ready        (req_ready),
    .img_addr         (img_addr),
    .img_rd           (img_rd),
    .img_data         (img_data),
    .res_valid        (res_valid),
    .res_op           (res_op),
    .res_window       (res_window),
    .res_sum          (res_sum),
    .host_busy        (host_busy),
    .lcd_cmd          (lcd_cmd),
    .lcd_cmd_valid    (lcd_cmd_valid),
    .lcd_datain       (lcd_datain),
    .lcd_dataout      (lcd_dataout),
    .lcd_output_valid (lcd_output_valid),
    .lcd_busy         (lcd_busy)
  );

  // ---------------- behavioural controller ----------------
  logic [7:0] m_img [0:35];
  int         m_t   = 0;
  int         m_row = 2;
  int         m_col = 2;
  logic [2:0] m_cmd = 3'd0;
  logic [2:0] s_cmd;
  logic [7:0] s_datain;

  initial begin
    for (int i = 0; i < 36; i++) m_img[i] = 8'd0;
  end

  // Host outputs are snapshotted mid-cycle so the edge process sees stable
  // values for the cycle that just ended.
  always @(negedge clk) begin
    s_cmd    = lcd_cmd;
    s_datain = lcd_datain;
  end

  function automatic logic [7:0] m_byte(input int j);
    return m_img[(m_row + j / 3) * 6 + m_col + j % 3];
  endfunction

  always @(posedge clk) begin
    int first;
    if (reset) begin
      m_t   = 0;
      m_cmd = 3'd0;
      #1;
      lcd_busy         = 1'b0;
      lcd_output_valid = 1'b0;
      lcd_dataout      = 8'd0;
    end else begin
      if (!lcd_busy) begin
        m_cmd = s_cmd;
        m_t   = 1;
        case (m_cmd)
          3'd1: begin m_row = 2; m_col = 2; end
          3'd2: if (m_col < 3) m_col = m_col + 1;
          3'd3: if (m_col > 0) m_col = m_col - 1;
          3'd4: if (m_row > 0) m_row = m_row - 1;
          3'd5: if (m_row < 3) m_row = m_row + 1;
          default: ;
        endcase
      end else begin
        if (m_cmd == 3'd1 && m_t >= 1 && m_t <= 36) m_img[m_t - 1] = s_datain;
        m_t = m_t + 1;
      end
      first = (m_cmd == 3'd1) ? 38 : 3;
      #1;
      if (m_t >= first && m_t <= first + 8) begin
        lcd_output_valid = 1'b1;
        lcd_dataout      = m_byte(m_t - first);
      end else begin
        lcd_output_valid = 1'b0;
        lcd_dataout      = 8'd0;
      end
      lcd_busy = (m_t != first + 8);
    end
  end

  // ---------------- bench plumbing ----------------
  logic [5:0] addr_tr [0:35];
  logic       rd_tr   [0:35];
  logic [7:0] din_tr  [0:35];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Places one request, waits for its issue and for its result. lat and nxt
  // are cycle offsets from the issue cycle of the result pulse and of the
  // next command slot.
  task automatic run_req(input logic [2:0] op, output logic [2:0] iss_cmd,
                         output int lat, output int nxt, output logic [71:0] win,
                         output logic [11:0] sum, output logic [2:0] rop);
    int w;
    lat = -1; nxt = -1; iss_cmd = 3'd0; win = 72'd0; sum = 12'd0; rop = 3'd0;
    req_valid = 1'b1;
    req_op    = op;
    step();
    req_valid = 1'b0;
    w = 0;
    while (!(lcd_cmd_valid && !req_ready) && w < 60) begin
      step();
      w++;
    end
    if (w >= 60) begin
      total++; bad++;
      $display("FAIL issue_timeout op=%0d got no issue within 60 cycles", op);
    end else begin
      iss_cmd = lcd_cmd;
      for (int t = 1; t <= 70 && lat < 0; t++) begin
        step();
        if (t <= 36) begin
          addr_tr[t - 1] = img_addr;
          rd_tr[t - 1]   = img_rd;
          din_tr[t - 1]  = lcd_datain;
        end
        if (lcd_cmd_valid && nxt < 0) nxt = t;
        if (res_valid) begin
          lat = t; win = res_window; sum = res_sum; rop = res_op;
        end
      end
      if (lat < 0) begin
        total++; bad++;
        $display("FAIL result_timeout op=%0d got no res_valid within 70 cycles", op);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++; if (res_op !== 3'd0) begin bad++; $display("FAIL reset_res_op got=%0d want=0", res_op); end
    total++; if (res_window !== 72'd0) begin bad++; $display("FAIL reset_res_window got=%h want=0", res_window); end
    total++; if (res_sum !== 12'd0) begin bad++; $display("FAIL reset_res_sum got=%0d want=0", res_sum); end
    total++; if (host_busy !== 1'b0) begin bad++; $display("FAIL reset_host_busy got=%b want=0", host_busy); end
    total++; if (img_addr !== 6'd0) begin bad++; $display("FAIL reset_img_addr got=%0d want=0", img_addr); end
    total++; if (img_rd !== 1'b0) begin bad++; $display("FAIL reset_img_rd got=%b want=0", img_rd); end
    total++; if (lcd_datain !== 8'd0) begin bad++; $display("FAIL reset_lcd_datain got=%0d want=0", lcd_datain); end
    reset = 1'b0;
    #1;
    total++; if (lcd_cmd_valid !== 1'b1) begin bad++; $display("FAIL reset_first_issue got=%b want=1", lcd_cmd_valid); end
    total++; if (lcd_cmd !== 3'd0) begin bad++; $display("FAIL reset_first_cmd got=%0d want=0", lcd_cmd); end
    $display("reset: outputs at reset values, refresh slot open after release");
  endtask

  task automatic test_idle();
    int pulses = 0, first = -1, last = -1, bad_gap = 0, bad_cmd = 0, rv = 0, nr = 0;
    for (int n = 1; n <= 45; n++) begin
      step();
      if (lcd_cmd_valid) begin
        if (first < 0) first = n;
        else if (n - last != 11) bad_gap++;
        if (lcd_cmd !== 3'd0) bad_cmd++;
        last = n;
        pulses++;
      end
      if (res_valid !== 1'b0) rv++;
      if (req_ready !== 1'b1) nr++;
    end
    total++; if (first != 11) begin bad++; $display("FAIL idle_first_slot got=%0d want=11", first); end
    total++; if (pulses != 4) begin bad++; $display("FAIL idle_slot_count got=%0d want=4", pulses); end
    total++; if (bad_gap != 0) begin bad++; $display("FAIL idle_slot_gap got=%0d bad gaps want=0", bad_gap); end
    total++; if (bad_cmd != 0) begin bad++; $display("FAIL idle_cmd got=%0d nonzero cmds want=0", bad_cmd); end
    total++; if (rv != 0) begin bad++; $display("FAIL idle_res_valid got=%0d pulses want=0", rv); end
    total++; if (nr != 0) begin bad++; $display("FAIL idle_req_ready got=%0d low cycles want=0", nr); end
    $display("idle: %0d refresh slots, first at %0d", pulses, first);
  endtask

  task automatic test_load(input string tag);
    logic [2:0] ic, rop; int lat, nxt; logic [71:0] win; logic [11:0] sum;
    int bad_addr = 0, bad_rd = 0, bad_din = 0;
    run_req(3'd1, ic, lat, nxt, win, sum, rop);
    for (int k = 0; k < 36; k++) begin
      if (addr_tr[k] !== 6'(k)) bad_addr++;
      if (rd_tr[k] !== 1'b1) bad_rd++;
      if (din_tr[k] !== 8'(k)) bad_din++;
    end
    total++; if (ic !== 3'd1) begin bad++; $display("FAIL %s_issue_cmd got=%0d want=1", tag, ic); end
    total++; if (bad_addr != 0) begin bad++; $display("FAIL %s_img_addr_seq got=%0d wrong want=0", tag, bad_addr); end
    total++; if (bad_rd != 0) begin bad++; $display("FAIL %s_img_rd got=%0d low want=0", tag, bad_rd); end
    total++; if (bad_din != 0) begin bad++; $display("FAIL %s_datain got=%0d wrong want=0", tag, bad_din); end
    total++; if (lat != 47) begin bad++; $display("FAIL %s_latency got=%0d want=47", tag, lat); end
    total++; if (nxt != 46) begin bad++; $display("FAIL %s_next_issue got=%0d want=46", tag, nxt); end
    total++; if (win !== {8'd28, 8'd27, 8'd26, 8'd22, 8'd21, 8'd20, 8'd16, 8'd15, 8'd14}) begin
      bad++; $display("FAIL %s_window got=%h want=1c1b1a161514100f0e", tag, win); end
    total++; if (sum !== 12'd189) begin bad++; $display("FAIL %s_sum got=%0d want=189", tag, sum); end
    total++; if (rop !== 3'd1) begin bad++; $display("FAIL %s_res_op got=%0d want=1", tag, rop); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL %s_pulse_width got=%b want=0", tag, res_valid); end
    total++; if (img_rd !== 1'b0) begin bad++; $display("FAIL %s_img_rd_after got=%b want=0", tag, img_rd); end
    $display("%s: latency=%0d next=%0d sum=%0d op=%0d", tag, lat, nxt, sum, rop);
  endtask

  task automatic test_shift_right(input string tag);
    logic [2:0] ic, rop; int lat, nxt; logic [71:0] win; logic [11:0] sum;
    run_req(3'd2, ic, lat, nxt, win, sum, rop);
    total++; if (ic !== 3'd2) begin bad++; $display("FAIL %s_issue_cmd got=%0d want=2", tag, ic); end
    total++; if (lat != 12) begin bad++; $display("FAIL %s_latency got=%0d want=12", tag, lat); end
    total++; if (nxt != 11) begin bad++; $display("FAIL %s_next_issue got=%0d want=11", tag, nxt); end
    total++; if (win !== {8'd29, 8'd28, 8'd27, 8'd23, 8'd22, 8'd21, 8'd17, 8'd16, 8'd15}) begin
      bad++; $display("FAIL %s_window got=%h want=1d1c1b17161511100f", tag, win); end
    total++; if (sum !== 12'd198) begin bad++; $display("FAIL %s_sum got=%0d want=198", tag, sum); end
    total++; if (rop !== 3'd2) begin bad++; $display("FAIL %s_res_op got=%0d want=2", tag, rop); end
    $display("%s: latency=%0d sum=%0d op=%0d", tag, lat, sum, rop);
  endtask

  task automatic test_shift_up();
    logic [2:0] ic, rop; int lat, nxt; logic [71:0] win; logic [11:0] sum;
    run_req(3'd4, ic, lat, nxt, win, sum, rop);
    total++; if (lat != 12) begin bad++; $display("FAIL up_latency got=%0d want=12", lat); end
    total++; if (win !== {8'd22, 8'd21, 8'd20, 8'd16, 8'd15, 8'd14, 8'd10, 8'd9, 8'd8}) begin
      bad++; $display("FAIL up_window got=%h want=161514100f0e0a0908", win); end
    total++; if (sum !== 12'd135) begin bad++; $display("FAIL up_sum got=%0d want=135", sum); end
    total++; if (rop !== 3'd4) begin bad++; $display("FAIL up_res_op got=%0d want=4", rop); end
    $display("up: latency=%0d sum=%0d op=%0d", lat, sum, rop);
  endtask

  task automatic test_back_to_back();
    int w = 0, ready_hi = 0, n = 0, t1 = -1, t2 = -1;
    logic [2:0] c1, c2 = 3'd7, o1 = 3'd7, o2 = 3'd7;
    logic [11:0] s1 = 12'd0, s2 = 12'd0;
    req_valid = 1'b1;
    req_op    = 3'd4;
    step();
    req_op = 3'd5;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_after_accept got=%b want=0", req_ready); end
    while (!lcd_cmd_valid && w < 30) begin
      step();
      if (req_ready !== 1'b0) ready_hi++;
      w++;
    end
    c1 = lcd_cmd;
    total++; if (ready_hi != 0 || w >= 30) begin bad++; $display("FAIL b2b_ready_held got=%0d high cycles (wait %0d) want=0", ready_hi, w); end
    total++; if (c1 !== 3'd4) begin bad++; $display("FAIL b2b_first_cmd got=%0d want=4", c1); end
    step();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_issue got=%b want=1", req_ready); end
    step();
    req_valid = 1'b0;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", req_ready); end
    for (int k = 2; k <= 40 && t2 < 0; k++) begin
      if (lcd_cmd_valid && !req_ready) c2 = lcd_cmd;
      if (res_valid) begin
        if (t1 < 0) begin t1 = k; o1 = res_op; s1 = res_sum; end
        else begin t2 = k; o2 = res_op; s2 = res_sum; end
      end
      n = k;
      if (t2 < 0) step();
    end
    total++; if (c2 !== 3'd5) begin bad++; $display("FAIL b2b_second_cmd got=%0d want=5", c2); end
    total++; if (t1 != 12) begin bad++; $display("FAIL b2b_first_result got=%0d want=12", t1); end
    total++; if (t2 - t1 != 11 || t2 < 0) begin bad++; $display("FAIL b2b_result_gap got=%0d want=11", t2 - t1); end
    total++; if (o1 !== 3'd4 || o2 !== 3'd5) begin bad++; $display("FAIL b2b_res_ops got=%0d,%0d want=4,5", o1, o2); end
    total++; if (s1 !== 12'd81 || s2 !== 12'd135) begin bad++; $display("FAIL b2b_sums got=%0d,%0d want=81,135", s1, s2); end
    $display("back_to_back: results at %0d and %0d ops %0d,%0d sums %0d,%0d (scan %0d)", t1, t2, o1, o2, s1, s2, n);
  endtask

  task automatic test_reset_mid_load();
    int w = 0, rv = 0;
    req_valid = 1'b1;
    req_op    = 3'd1;
    step();
    req_valid = 1'b0;
    while (!(lcd_cmd_valid && !req_ready) && w < 60) begin step(); w++; end
    total++; if (w >= 60) begin bad++; $display("FAIL midload_issue got=timeout want=issue"); end
    for (int k = 1; k <= 10; k++) step();
    total++; if (img_rd !== 1'b1 || img_addr !== 6'd9) begin
      bad++; $display("FAIL midload_progress got=rd%b addr%0d want=rd1 addr9", img_rd, img_addr); end
    reset = 1'b1;
    #1;
    total++; if (img_rd !== 1'b0 || img_addr !== 6'd0 || lcd_datain !== 8'd0) begin
      bad++; $display("FAIL midload_reset_stream got=rd%b addr%0d din%0d want=0,0,0", img_rd, img_addr, lcd_datain); end
    total++; if (req_ready !== 1'b1 || host_busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL midload_reset_ctl got=rdy%b busy%b rv%b want=1,0,0", req_ready, host_busy, res_valid); end
    total++; if (res_window !== 72'd0 || res_sum !== 12'd0 || res_op !== 3'd0) begin
      bad++; $display("FAIL midload_reset_result got=%h/%0d/%0d want=0/0/0", res_window, res_sum, res_op); end
    step();
    reset = 1'b0;
    #1;
    total++; if (lcd_cmd_valid !== 1'b1 || lcd_cmd !== 3'd0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL midload_first_issue got=v%b cmd%0d rdy%b want=1,0,1", lcd_cmd_valid, lcd_cmd, req_ready); end
    for (int k = 0; k < 14; k++) begin
      step();
      if (res_valid !== 1'b0) rv++;
    end
    total++; if (rv != 0) begin bad++; $display("FAIL midload_untracked got=%0d res pulses want=0", rv); end
    $display("reset_mid_load: streaming cleared, untracked refresh produced no result");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_idle();
    test_load("load");
    test_shift_right("right1");
    test_shift_right("right2");
    test_load("reload");
    test_shift_up();
    test_back_to_back();
    test_reset_mid_load();
    test_load("load_after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_host.md
# lcd_host

Command initiator for the 6x6-image / 3x3-window LCD controller. It sits between a request source and the controller's `cmd`/`datain`/`dataout` port set. It queues one request at a time and issues it in the controller's single command-accept cycle. For load commands it streams the 36 image bytes from an image memory. It collects the nine returned window bytes and presents them as one packed result with a checksum. It also fills every idle command slot with an untracked refresh, because the controller samples `cmd` whenever `busy` is low.

## Interface
Parameters:
- none; image is fixed at 6x6 bytes and the window at 3x3.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_op  in  3  0 refresh, 1 load, 2 right, 3 left, 4 up, 5 down; 6-7 treated as refresh
- req_ready  out  1  holding register empty (= !hold_valid)
- img_addr  out  6  image byte address during load, else 0
- img_rd  out  1  high while streaming load bytes
- img_data  in  8  image byte, combinational read of img_addr
- res_valid  out  1  one-cycle pulse, result of a tracked request
- res_op  out  3  op of the completed request
- res_window  out  72  byte i in [8i+7:8i], i = 0..8 raster order
- res_sum  out  12  unsigned sum of the nine window bytes
- host_busy  out  1  hold_valid | inflight_tracked
- lcd_cmd  out  3  command to controller
- lcd_cmd_valid  out  1  command strobe
- lcd_datain  out  8  load byte to controller
- lcd_dataout  in  8  window byte from controller
- lcd_output_valid  in  1  window byte strobe
- lcd_busy  in  1  controller busy; low = command-accept cycle

## Operation
- **Request accept:** on `req_valid & req_ready`, latch `req_op` into the hold register and set `hold_valid`. There is no bypass, so the earliest issue is the next accept cycle.
- **Issue (combinational):**
  - `lcd_cmd_valid = !lcd_busy`.
  - `lcd_cmd` = held op if `hold_valid`, else 0.
- **Issue (registered):** at the edge ending an issue cycle:
  - clear `hold_valid`;
  - set `inflight_tracked = hold_valid` and `inflight_op = op`;
  - if op = 1, enter LOAD.
- **State machine** (streaming side): IDLE and LOAD.
  - IDLE to LOAD on issue of op 1.
  - In LOAD, the 6-bit counter k runs 0..35: `img_addr = k`, `img_rd = 1`, `lcd_datain = img_data`.
  - LOAD to IDLE after k = 35.
  - Outside LOAD, `lcd_datain = 0`.
- **Capture:** every cycle with `lcd_output_valid`:
  - shift `lcd_dataout` into the window register;
  - add it into the running sum;
  - increment the 4-bit byte count.
- **Completion:** on the 9th byte, at the same edge:
  - if `inflight_tracked` (old value), pulse `res_valid` next cycle with `res_window`, `res_sum`, `res_op = inflight_op`;
  - clear count and sum.
  - Untracked windows are discarded.
- **Completion/issue overlap:** the 9th byte coincides with `lcd_busy` low, i.e. the next issue. Completion must use the pre-edge `inflight_*` values.
- **Arithmetic:** 12-bit sum, no overflow (max 2295).
- **Boundary behaviour:** the host does not clamp shifts; edge clamping is the controller's job. Ops 6-7 are sent as 0.

## Timing
- **Reset values:**
  - req_ready = 1, res_valid = 0, res_op = 0, res_window = 0, res_sum = 0, host_busy = 0, img_addr = 0, img_rd = 0.
  - lcd_datain = 0, with state IDLE, count = 0, inflight_tracked = 0.
  - `lcd_cmd_valid` follows `!lcd_busy` immediately, so an untracked refresh is issued in the first cycle.
- **Refresh/shift issued in cycle c:**
  - bytes arrive c+3..c+11;
  - next issue at c+11;
  - `res_valid` at c+12.
- **Load issued in cycle c:**
  - `img_addr = k` in cycle c+1+k (c+1..c+36);
  - bytes arrive c+38..c+46;
  - `res_valid` at c+47;
  - next issue at c+46.
- **Reset mid-operation:** asynchronously returns everything to the reset values. Partial window, hold and load progress are lost, and no `res_valid` is produced.

## Test plan
- **Idle:** reset then no requests -> `lcd_cmd_valid` pulses with `lcd_cmd` = 0 every 11 cycles; `res_valid` never asserts; `req_ready` stays 1.
- **Load:** `img_data = img_addr`; load request -> `img_addr` 0..35 in consecutive cycles; `res_window` bytes 14,15,16,20,21,22,26,27,28; `res_sum` = 189; `res_op` = 1; `res_valid` 47 cycles after issue.
- **Shift right:** after the load, right -> bytes 15,16,17,21,22,23,27,28,29, sum 198. Second right -> same window, sum 198 (controller clamps).
- **Shift up:** after a fresh load, up -> bytes 8,9,10,14,15,16,20,21,22, sum 135.
- **Back-to-back:** `req_valid` held with ops 4 then 5:
  - `req_ready` is low from the accept edge until the issue edge;
  - the second op is accepted in the cycle after the first issues;
  - two `res_valid` pulses are produced, 11 cycles apart, with `res_op` 4 then 5.
- **Reset mid-load:** reset asserted at c+10 of a load -> all outputs at reset values. After release, the first issue is an untracked refresh with no `res_valid`, and a subsequent load completes normally.
